// File: rtl/i16356_mon_pkg.sv
// Shared types and default widths for the I16356 trigger monitor.
package i16356_mon_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    ARMED     = 2'd2,
    TRIGGERED = 2'd3
  } mon_state_t;

  localparam int unsigned HIST_W_D = 8;
  localparam int unsigned CNT_W_D  = 8;
  localparam int unsigned CNT_MAX  = (1 << CNT_W_D) - 1;

endpackage

// File: rtl/i16356_trigger_monitor_if.sv
// Observation/control bundle between the harness and the trigger monitor.
interface i16356_trigger_monitor_if
  import i16356_mon_pkg::*;
#(
  parameter int unsigned HIST_W = HIST_W_D,
  parameter int unsigned CNT_W  = CNT_W_D
);

  logic              I16356;
  logic              en;
  logic              clr;
  logic [HIST_W-1:0] pattern;
  logic [HIST_W-1:0] mask;
  logic [HIST_W-1:0] hist;
  logic              hit;
  logic [CNT_W-1:0]  match_cnt;
  logic              trig;
  logic              armed;

  modport master (
    output I16356, en, clr, pattern, mask,
    input  hist, hit, match_cnt, trig, armed
  );

  modport slave (
    input  I16356, en, clr, pattern, mask,
    output hist, hit, match_cnt, trig, armed
  );

endinterface

// File: rtl/i16356_hist_sr.sv
// History shift register plus fill counter; flags the sample that completes a fill.
module i16356_hist_sr
  import i16356_mon_pkg::*;
#(
  parameter int unsigned HIST_W = HIST_W_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic [HIST_W-1:0] hist,
  output logic              fill_last_c
);

  localparam int unsigned FILL_W = $clog2(HIST_W + 1);

  logic [HIST_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  // Fill counter stops at HIST_W; it only matters until the first full history.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = {hist_q[HIST_W-2:0], din};
      if (fill_q != FILL_W'(HIST_W)) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hist        = hist_q;
  assign fill_last_c = (fill_q == FILL_W'(HIST_W - 1));

endmodule

// File: rtl/i16356_trigger_monitor.sv
// Sequential trojan-detection stage: masked history compare, saturating match count,
// sticky trigger once the count reaches THRESH.
module i16356_trigger_monitor
  import i16356_mon_pkg::*;
#(
  parameter int unsigned HIST_W = HIST_W_D,
  parameter int unsigned CNT_W  = CNT_W_D,
  parameter int unsigned THRESH = 4
) (
  input  logic                      I1470,
  input  logic                      I1477,
  i16356_trigger_monitor_if.slave   mon
);

  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

  mon_state_t        state_q, state_d;
  logic              hit_q, hit_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              trig_q, trig_d;
  logic              armed_q, armed_d;

  logic [HIST_W-1:0] hist;
  logic              fill_last_c;
  logic              match_c;
  logic [CNT_W-1:0]  cnt_inc_c;

  i16356_hist_sr #(
    .HIST_W (HIST_W)
  ) u_hist_sr (
    .clk         (I1470),
    .rst_n       (I1477),
    .clr         (mon.clr),
    .en          (mon.en),
    .din         (mon.I16356),
    .hist        (hist),
    .fill_last_c (fill_last_c)
  );

  // Compare uses the pre-shift history; an empty mask is treated as never matching.
  assign match_c   = (((hist ^ mon.pattern) & mon.mask) == '0) && (mon.mask != '0);
  assign cnt_inc_c = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    hit_d   = 1'b0;
    cnt_d   = cnt_q;
    trig_d  = trig_q;
    armed_d = armed_q;
    if (mon.clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      trig_d  = 1'b0;
      armed_d = 1'b0;
    end else if (mon.en) begin
      unique case (state_q)
        IDLE: state_d = FILL;
        FILL: begin
          if (fill_last_c) begin
            state_d = ARMED;
            armed_d = 1'b1;
          end
        end
        ARMED, TRIGGERED: begin
          if (match_c) begin
            hit_d = 1'b1;
            cnt_d = cnt_inc_c;
            if ((state_q == ARMED) && (cnt_inc_c == THRESH_V)) begin
              state_d = TRIGGERED;
              trig_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge I1470 or negedge I1477) begin
    if (!I1477) begin
      state_q <= IDLE;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
      armed_q <= armed_d;
    end
  end

  assign mon.hist      = hist;
  assign mon.hit       = hit_q;
  assign mon.match_cnt = cnt_q;
  assign mon.trig      = trig_q;
  assign mon.armed     = armed_q;

endmodule

// File: tb/tb_i16356_trigger_monitor.sv
// Self-checking bench: two monitor instances driven identically, checked against a sample-count model.
module tb_i16356_trigger_monitor;

  logic I1470 = 1'b0;
  logic I1477;

  always #5 I1470 = ~I1470;

  i16356_trigger_monitor_if #(.HIST_W(8), .CNT_W(8)) mi0 ();
  i16356_trigger_monitor_if #(.HIST_W(8), .CNT_W(2)) mi1 ();

  i16356_trigger_monitor #(.HIST_W(8), .CNT_W(8), .THRESH(2)) dut0 (
    .I1470 (I1470),
    .I1477 (I1477),
    .mon   (mi0)
  );

  i16356_trigger_monitor #(.HIST_W(8), .CNT_W(2), .THRESH(3)) dut1 (
    .I1470 (I1470),
    .I1477 (I1477),
    .mon   (mi1)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: history as a number, count of samples taken since clear.
  int unsigned m_hist[2];
  int unsigned m_n[2];
  int unsigned m_cnt[2];
  int unsigned m_hit[2];
  int unsigned c_max[2];
  int unsigned thr[2];

  logic [7:0] pat;
  logic [7:0] msk;
  bit         cur_e, cur_c, cur_d;
  bit         seq[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_hist[i] = 0; m_n[i] = 0; m_cnt[i] = 0; m_hit[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (cur_c) begin
        m_hist[i] = 0; m_n[i] = 0; m_cnt[i] = 0; m_hit[i] = 0;
      end else if (cur_e) begin
        m_hit[i] = 0;
        if (m_n[i] >= 8 && msk != 0 && ((m_hist[i] ^ pat) & msk) == 0) begin
          m_hit[i] = 1;
          if (m_cnt[i] < c_max[i]) m_cnt[i] = m_cnt[i] + 1;
        end
        m_hist[i] = ((m_hist[i] << 1) | cur_d) & 8'hFF;
        if (m_n[i] < 8) m_n[i] = m_n[i] + 1;
      end else begin
        m_hit[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("hist0",  32'(mi0.hist),      m_hist[0]);
    chk("hit0",   32'(mi0.hit),       m_hit[0]);
    chk("cnt0",   32'(mi0.match_cnt), m_cnt[0]);
    chk("trig0",  32'(mi0.trig),      32'(m_cnt[0] >= thr[0]));
    chk("armed0", 32'(mi0.armed),     32'(m_n[0] >= 8));
    chk("hist1",  32'(mi1.hist),      m_hist[1]);
    chk("hit1",   32'(mi1.hit),       m_hit[1]);
    chk("cnt1",   32'(mi1.match_cnt), m_cnt[1]);
    chk("trig1",  32'(mi1.trig),      32'(m_cnt[1] >= thr[1]));
    chk("armed1", 32'(mi1.armed),     32'(m_n[1] >= 8));
  endtask

  task automatic drive(input bit e, input bit c, input bit d);
    cur_e = e; cur_c = c; cur_d = d;
    mi0.en = e; mi0.clr = c; mi0.I16356 = d; mi0.pattern = pat; mi0.mask = msk;
    mi1.en = e; mi1.clr = c; mi1.I16356 = d; mi1.pattern = pat; mi1.mask = msk;
  endtask

  task automatic step(input bit e, input bit c, input bit d);
    drive(e, c, d);
    @(posedge I1470);
    model_edge();
    #1;
    check_all();
  endtask

  // Reset asserted between edges, checked before the next edge, released on a falling edge.
  task automatic async_rst();
    #2;
    I1477 = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge I1470);
    #1;
    check_all();
    @(negedge I1470);
    I1477 = 1'b1;
  endtask

  initial begin
    int hits;
    c_max[0] = i16356_mon_pkg::CNT_MAX; thr[0] = 2;
    c_max[1] = 3;                       thr[1] = 3;
    pat = 8'hA5; msk = 8'hFF;
    I1477 = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    model_reset();
    #1;
    check_all();
    @(posedge I1470);
    @(negedge I1470);
    I1477 = 1'b1;

    // Fill with A5, oldest bit first
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, seq[k]);
    chk("fill_hist_a5", 32'(mi0.hist), 32'h0000_00A5);
    chk("fill_armed",   32'(mi0.armed), 32'd1);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, seq[k]);
      if (k == 0) begin
        chk("first_hit",  32'(mi0.hit),       32'd1);
        chk("first_cnt",  32'(mi0.match_cnt), 32'd1);
        chk("first_trig", 32'(mi0.trig),      32'd0);
      end
    end
    step(1'b1, 1'b0, seq[0]);
    chk("second_hit",  32'(mi0.hit),       32'd1);
    chk("second_cnt",  32'(mi0.match_cnt), 32'd2);
    chk("second_trig", 32'(mi0.trig),      32'd1);
    for (int k = 1; k < 8; k++) step(1'b1, 1'b0, seq[k]);
    step(1'b1, 1'b0, seq[0]);
    chk("trig_sticky", 32'(mi0.trig), 32'd1);
    chk("trig1_third", 32'(mi1.trig), 32'd1);

    // Masked compare on the low nibble
    step(1'b1, 1'b1, 1'b1);
    chk("clr_hist", 32'(mi0.hist), 32'd0);
    pat = 8'h05; msk = 8'h0F;
    for (int k = 0; k < 24; k++) step(1'b1, 1'b0, bit'(k % 2));
    msk = 8'h00;
    hits = 0;
    for (int k = 0; k < 32; k++) begin
      step(1'b1, 1'b0, 1'($urandom));
      hits += int'(mi0.hit);
    end
    chk("mask0_hits", 32'(hits), 32'd0);

    // Enable gap in the middle of a fill
    pat = 8'hA5; msk = 8'hFF;
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, seq[k]);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'($urandom));
    chk("gap_hist",  32'(mi0.hist),  32'h0000_0005);
    chk("gap_armed", 32'(mi0.armed), 32'd0);
    for (int k = 3; k < 7; k++) step(1'b1, 1'b0, seq[k]);
    chk("gap_not_yet", 32'(mi0.armed), 32'd0);
    step(1'b1, 1'b0, seq[7]);
    chk("gap_armed_late", 32'(mi0.armed), 32'd1);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_en_hist",  32'(mi0.hist),  32'd0);
    chk("clr_en_armed", 32'(mi0.armed), 32'd0);

    // Saturation: only bit 0 compared, input held high
    pat = 8'h01; msk = 8'h01;
    for (int k = 0; k < 300; k++) step(1'b1, 1'b0, 1'b1);
    chk("sat_cnt1",  32'(mi1.match_cnt), 32'd3);
    chk("sat_hit1",  32'(mi1.hit),       32'd1);
    chk("sat_trig1", 32'(mi1.trig),      32'd1);
    chk("sat_cnt0",  32'(mi0.match_cnt), 32'd255);

    // Asynchronous reset while armed, then a full re-fill
    step(1'b1, 1'b1, 1'b0);
    pat = 8'hA5; msk = 8'hFF;
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, seq[k % 8]);
    async_rst();
    chk("arst_armed", 32'(mi0.armed), 32'd0);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 1'($urandom));
    chk("refill_not_yet", 32'(mi0.armed), 32'd0);
    step(1'b1, 1'b0, 1'($urandom));
    chk("refill_armed", 32'(mi0.armed), 32'd1);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        pat = 8'($urandom);
        msk = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom & $urandom & $urandom);
      end
      if ($urandom_range(0, 199) == 0) async_rst();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
